wb_port: RTL

WB_PORT -- requirements
Module: wb_port

---
 rtl/wb_port.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_port.sv
// Register-file write port arbiter: merges the 1-cycle pipeline writeback with a
// small FIFO of long-latency results and tracks which registers await such results.
module wb_port #(
   parameter int unsigned QDEPTH = 2
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    pipe_wr_en,
   input  logic [4:0]              pipe_rd,
   input  logic [31:0]             pipe_data,
   input  logic                    lu_valid,
   output logic                    lu_ready,
   input  logic [4:0]              lu_rd,
   input  logic [31:0]             lu_data,
   input  logic                    issue_en,
   input  logic [4:0]              issue_rd,
   output logic [4:0]              rwd,
   output logic [31:0]             wb_data,
   output logic [31:0]             busy_mask,
   output logic [$clog2(QDEPTH):0] q_count
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   logic [4:0]    ent_rd_q   [QDEPTH];
   logic [31:0]   ent_data_q [QDEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic [4:0]    rwd_q, rwd_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic [31:0]   busy_q, busy_d;

   logic          pipe_req;
   logic          pop;
   logic          push;
   logic [31:0]   set_mask;
   logic [31:0]   clr_mask;

   // Write-port selection, queue bookkeeping and busy-mask next state.
   // Pop decisions use the queue contents before this edge, so an entry pushed
   // at an edge can only be written at a later edge.
   always_comb begin
      pipe_req  = pipe_wr_en && (pipe_rd != 5'd0);
      pop       = !pipe_req && (count_q != '0);
      // ready_q gates acceptance; a zero destination is accepted but dropped
      push      = lu_valid && ready_q && (lu_rd != 5'd0);

      rwd_d     = 5'd0;
      wb_data_d = 32'd0;
      if (pipe_req) begin
         rwd_d     = pipe_rd;
         wb_data_d = pipe_data;
      end else if (pop) begin
         rwd_d     = ent_rd_q[rd_ptr_q];
         wb_data_d = ent_data_q[rd_ptr_q];
      end

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ready_d  = count_d < CW'(QDEPTH);

      // a same-edge issue to the popped register must keep the bit set
      clr_mask = pop ? (32'd1 << ent_rd_q[rd_ptr_q]) : 32'd0;
      set_mask = (issue_en && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
      busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
   end

   // Control state and registered outputs; reset clears everything at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ready_q   <= 1'b0;
         rwd_q     <= 5'd0;
         wb_data_q <= 32'd0;
         busy_q    <= 32'd0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ready_q   <= ready_d;
         rwd_q     <= rwd_d;
         wb_data_q <= wb_data_d;
         busy_q    <= busy_d;
      end
   end

   // Queue storage; contents are only meaningful under the pointers, so no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         ent_rd_q[wr_ptr_q]   <= lu_rd;
         ent_data_q[wr_ptr_q] <= lu_data;
      end
   end

   assign lu_ready  = ready_q;
   assign rwd       = rwd_q;
   assign wb_data   = wb_data_q;
   assign busy_mask = busy_q;
   assign q_count   = count_q;

endmodule
